// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end definitions: bubble encoding, default reset PC
// and the fetch-stage state encoding.
package riscv_pkg;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;

    // Redirect targets may carry low bits from the ALU; fetch is word-aligned.
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return addr & ~32'h0000_0003;
    endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry holding slot for an instruction that returned while decode was stalled.
module fetch_skid_buf (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic        clear,
    input  logic [31:0] new_instr,
    input  logic [31:0] new_pc,
    output logic        valid,
    output logic [31:0] instr,
    output logic [31:0] pc
);

    // Clear wins over load: a redirect must never leave a stale entry behind.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid <= 1'b0;
            instr <= 32'h0;
            pc    <= 32'h0;
        end else if (clear) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            instr <= new_instr;
            pc    <= new_pc;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, instruction-memory handshake,
// redirect handling and the IF/ID pipeline registers.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = riscv_pkg::DEFAULT_RESET_PC,
    parameter logic [31:0] NOP_INSTR = riscv_pkg::NOP_INSTR
) (
    input  logic                   clk,
    input  logic                   reset,
    output logic                   IMemReq,
    output logic [31:0]            IMemAddr,
    input  logic [31:0]            IMemRData,
    input  logic                   IMemValid,
    input  logic                   StallD,
    input  logic                   PCSrcE,
    input  logic [31:0]            PCTargetE,
    output logic [31:0]            InstrD,
    output logic [31:0]            PCD,
    output logic [31:0]            PCPlus4D,
    output logic                   ValidD,
    output logic [6:0]             OpD,
    output logic [2:0]             Funct3D,
    output logic                   Funct7_5D,
    output riscv_pkg::fetch_state_t fetch_state
);

    riscv_pkg::fetch_state_t state, state_next;

    logic [31:0] pcf;
    logic [31:0] pcf_next;
    logic [31:0] pc_plus4f;
    logic [31:0] drain_addr;
    logic        req;
    logic        accept;
    logic        buf_valid;
    logic [31:0] buf_instr;
    logic [31:0] buf_pc;
    logic        buf_load;
    logic        buf_clear;

    // Handshake: IMemReq/IMemAddr hold steady until IMemValid is seen high on a
    // rising edge while IMemReq=1; that edge completes the transfer. IMemValid may
    // already be high in the first cycle of the request.
    assign req      = (state == riscv_pkg::DRAIN) ||
                      ((state == riscv_pkg::FETCH) && !buf_valid);
    assign IMemReq  = req;
    assign IMemAddr = (state == riscv_pkg::DRAIN) ? drain_addr : pcf;
    assign accept   = (state == riscv_pkg::FETCH) && req && IMemValid && !PCSrcE;

    assign pc_plus4f = pcf + 32'd4;

    // Redirect mux: execute redirect beats sequential advance.
    always_comb begin
        pcf_next = pcf;
        if (PCSrcE) begin
            pcf_next = riscv_pkg::align_word(PCTargetE);
        end else if (accept) begin
            pcf_next = pc_plus4f;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pcf <= RESET_PC;
        end else begin
            pcf <= pcf_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= riscv_pkg::IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            riscv_pkg::IDLE: begin
                state_next = riscv_pkg::FETCH;
            end
            riscv_pkg::FETCH: begin
                // A redirect with the response still in flight must swallow it.
                if (PCSrcE && req && !IMemValid) begin
                    state_next = riscv_pkg::DRAIN;
                end
            end
            riscv_pkg::DRAIN: begin
                if (IMemValid) begin
                    state_next = riscv_pkg::FETCH;
                end
            end
            default: begin
                state_next = riscv_pkg::IDLE;
            end
        endcase
    end

    assign fetch_state = state;

    always_ff @(posedge clk) begin
        if (reset) begin
            drain_addr <= RESET_PC;
        end else if ((state == riscv_pkg::FETCH) && (state_next == riscv_pkg::DRAIN)) begin
            drain_addr <= pcf;
        end
    end

    assign buf_load  = accept && StallD;
    assign buf_clear = PCSrcE || (!StallD && buf_valid);

    fetch_skid_buf u_skid_buf (
        .clk       (clk),
        .reset     (reset),
        .load      (buf_load),
        .clear     (buf_clear),
        .new_instr (IMemRData),
        .new_pc    (pcf),
        .valid     (buf_valid),
        .instr     (buf_instr),
        .pc        (buf_pc)
    );

    // The skid entry is older than anything on the bus, so it drains first.
    always_ff @(posedge clk) begin
        if (reset) begin
            InstrD   <= NOP_INSTR;
            PCD      <= 32'h0;
            PCPlus4D <= 32'h0;
            ValidD   <= 1'b0;
        end else if (PCSrcE) begin
            InstrD <= NOP_INSTR;
            ValidD <= 1'b0;
        end else if (!StallD) begin
            if (buf_valid) begin
                InstrD   <= buf_instr;
                PCD      <= buf_pc;
                PCPlus4D <= buf_pc + 32'd4;
                ValidD   <= 1'b1;
            end else if (accept) begin
                InstrD   <= IMemRData;
                PCD      <= pcf;
                PCPlus4D <= pc_plus4f;
                ValidD   <= 1'b1;
            end else begin
                InstrD <= NOP_INSTR;
                ValidD <= 1'b0;
            end
        end
    end

    assign OpD       = InstrD[6:0];
    assign Funct3D   = InstrD[14:12];
    assign Funct7_5D = InstrD[30];

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a latency-programmable memory model feeds the
// fetch port, and a decode-side monitor checks each issued instruction in order.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset;
    logic        IMemReq;
    logic [31:0] IMemAddr;
    logic [31:0] IMemRData;
    logic        IMemValid;
    logic        StallD;
    logic        PCSrcE;
    logic [31:0] PCTargetE;
    logic [31:0] InstrD;
    logic [31:0] PCD;
    logic [31:0] PCPlus4D;
    logic        ValidD;
    logic [6:0]  OpD;
    logic [2:0]  Funct3D;
    logic        Funct7_5D;
    riscv_pkg::fetch_state_t fetch_state;

    int total = 0;
    int bad   = 0;
    int mem_delay = 0;
    int wait_cnt  = 0;
    logic stall_q;
    logic [95:0] exp_q[$];

    fetch_stage dut (
        .clk         (clk),
        .reset       (reset),
        .IMemReq     (IMemReq),
        .IMemAddr    (IMemAddr),
        .IMemRData   (IMemRData),
        .IMemValid   (IMemValid),
        .StallD      (StallD),
        .PCSrcE      (PCSrcE),
        .PCTargetE   (PCTargetE),
        .InstrD      (InstrD),
        .PCD         (PCD),
        .PCPlus4D    (PCPlus4D),
        .ValidD      (ValidD),
        .OpD         (OpD),
        .Funct3D     (Funct3D),
        .Funct7_5D   (Funct7_5D),
        .fetch_state (fetch_state)
    );

    // Clock / reset block
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected test end");
        $fatal(1, "watchdog");
    end

    // Memory model: the word is a fixed function of its address; the response
    // comes mem_delay cycles after the request first appears.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h5A5A_0033;
    endfunction

    assign IMemValid = IMemReq && (wait_cnt >= mem_delay);
    assign IMemRData = mem_word(IMemAddr);

    always @(posedge clk) begin
        if (reset || !IMemReq || IMemValid) wait_cnt <= 0;
        else wait_cnt <= wait_cnt + 1;
        stall_q <= StallD;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic expect_d(input logic [31:0] pc, input logic [31:0] pc4);
        exp_q.push_back({pc, pc4, mem_word(pc)});
    endtask

    // Scoreboard monitor: each decode load after an unstalled edge must match
    // the oldest expected entry.
    always @(negedge clk) begin
        logic [95:0] e;
        if (!reset && ValidD && stall_q === 1'b0) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_decode: got pc %h expected none", PCD);
            end else begin
                e = exp_q.pop_front();
                chk("pcd",      PCD,                 e[95:64]);
                chk("pcplus4d", PCPlus4D,            e[63:32]);
                chk("instrd",   InstrD,              e[31:0]);
                chk("opd",      {25'h0, OpD},        {25'h0, e[6:0]});
                chk("funct3d",  {29'h0, Funct3D},    {29'h0, e[14:12]});
                chk("funct7_5d",{31'h0, Funct7_5D},  {31'h0, e[30]});
            end
        end
    end

    // Driver: inputs change on the falling edge, direct checks sample there too.
    initial begin
        reset = 1'b1; StallD = 1'b0; PCSrcE = 1'b0; PCTargetE = 32'h0; mem_delay = 0;
        repeat (3) @(negedge clk);
        chk("rst_req",    {31'h0, IMemReq}, 32'h0);
        chk("rst_validd", {31'h0, ValidD},  32'h0);
        chk("rst_instrd", InstrD,           NOP);
        chk("rst_pcd",    PCD,              32'h0);
        chk("rst_pc4d",   PCPlus4D,         32'h0);
        reset = 1'b0;
        chk("idle_state", {30'h0, fetch_state}, {30'h0, riscv_pkg::IDLE});

        // Back-to-back fetch with single-cycle memory
        @(negedge clk);
        chk("seq_addr0", IMemAddr, 32'h0);
        chk("seq_req0", {31'h0, IMemReq}, 32'h1);
        expect_d(32'h0, 32'h4);
        @(negedge clk);
        chk("seq_addr4", IMemAddr, 32'h4);
        expect_d(32'h4, 32'h8);
        @(negedge clk);
        chk("seq_addr8", IMemAddr, 32'h8);

        // Stall while 0x8 returns: it lands in the skid buffer
        StallD = 1'b1;
        @(negedge clk);
        chk("stall_req", {31'h0, IMemReq}, 32'h0);
        chk("stall_pcd", PCD, 32'h4);
        chk("stall_validd", {31'h0, ValidD}, 32'h1);
        @(negedge clk);
        chk("stall2_pcd", PCD, 32'h4);
        chk("stall2_req", {31'h0, IMemReq}, 32'h0);
        StallD = 1'b0;
        expect_d(32'h8, 32'hC);
        @(negedge clk);
        chk("resume_req", {31'h0, IMemReq}, 32'h1);
        chk("resume_addr", IMemAddr, 32'hC);
        expect_d(32'hC, 32'h10);
        @(negedge clk);
        chk("addr10", IMemAddr, 32'h10);

        // Redirect coinciding with a response: response dropped
        PCSrcE = 1'b1; PCTargetE = 32'h100;
        @(negedge clk);
        PCSrcE = 1'b0;
        chk("redir_validd", {31'h0, ValidD}, 32'h0);
        chk("redir_instrd", InstrD, NOP);
        chk("redir_addr", IMemAddr, 32'h100);
        chk("redir_state", {30'h0, fetch_state}, {30'h0, riscv_pkg::FETCH});
        mem_delay = 3;

        // Redirect with the response still outstanding: drain it
        @(negedge clk);
        chk("pend_addr", IMemAddr, 32'h100);
        PCSrcE = 1'b1; PCTargetE = 32'h200;
        @(negedge clk);
        PCSrcE = 1'b0;
        chk("drain_state", {30'h0, fetch_state}, {30'h0, riscv_pkg::DRAIN});
        chk("drain_addr", IMemAddr, 32'h100);
        chk("drain_req", {31'h0, IMemReq}, 32'h1);
        @(negedge clk);
        chk("drain2_addr", IMemAddr, 32'h100);
        chk("drain2_validd", {31'h0, ValidD}, 32'h0);
        @(negedge clk);
        chk("post_drain_state", {30'h0, fetch_state}, {30'h0, riscv_pkg::FETCH});
        chk("post_drain_addr", IMemAddr, 32'h200);
        chk("post_drain_validd", {31'h0, ValidD}, 32'h0);
        mem_delay = 0;
        expect_d(32'h200, 32'h204);
        @(negedge clk);
        chk("addr204", IMemAddr, 32'h204);

        // Redirect while stalled with a full buffer; misaligned target
        StallD = 1'b1;
        @(negedge clk);
        chk("full_req", {31'h0, IMemReq}, 32'h0);
        PCSrcE = 1'b1; PCTargetE = 32'h203;
        @(negedge clk);
        PCSrcE = 1'b0; StallD = 1'b0;
        chk("flush_validd", {31'h0, ValidD}, 32'h0);
        chk("flush_instrd", InstrD, NOP);
        chk("flush_req", {31'h0, IMemReq}, 32'h1);
        chk("flush_addr", IMemAddr, 32'h200);
        expect_d(32'h200, 32'h204);
        @(negedge clk);
        chk("refetch_addr", IMemAddr, 32'h204);

        // Address wrap at the top of memory
        PCSrcE = 1'b1; PCTargetE = 32'hFFFF_FFFC;
        @(negedge clk);
        PCSrcE = 1'b0;
        chk("top_addr", IMemAddr, 32'hFFFF_FFFC);
        expect_d(32'hFFFF_FFFC, 32'h0000_0000);
        @(negedge clk);
        chk("wrap_addr", IMemAddr, 32'h0);
        expect_d(32'h0, 32'h4);

        // Reset while a request is outstanding
        @(negedge clk);
        mem_delay = 5;
        @(negedge clk);
        chk("mid_req", {31'h0, IMemReq}, 32'h1);
        chk("mid_addr", IMemAddr, 32'h4);
        chk("mid_validd", {31'h0, ValidD}, 32'h0);
        reset = 1'b1;
        @(negedge clk);
        chk("rst2_req", {31'h0, IMemReq}, 32'h0);
        chk("rst2_state", {30'h0, fetch_state}, {30'h0, riscv_pkg::IDLE});
        chk("rst2_pcd", PCD, 32'h0);
        reset = 1'b0; mem_delay = 0;
        @(negedge clk);
        chk("restart_addr", IMemAddr, 32'h0);
        chk("restart_state", {30'h0, fetch_state}, {30'h0, riscv_pkg::FETCH});
        expect_d(32'h0, 32'h4);
        @(negedge clk);
        chk("restart_addr4", IMemAddr, 32'h4);
        expect_d(32'h4, 32'h8);
        @(negedge clk);
        mem_delay = 100;
        @(negedge clk);
        chk("end_validd", {31'h0, ValidD}, 32'h0);
        chk("queue_empty", exp_q.size(), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 Parameter NOP_INSTR, default 32'h0000_0013 (addi x0,x0,0), bubble inserted into decode.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 IMemReq  out  1  instruction-memory request valid.
REQ-006 IMemAddr  out  32  fetch address; word-aligned.
REQ-007 IMemRData  in  32  returned instruction word.
REQ-008 IMemValid  in  1  response valid; may assert same cycle as IMemReq or any later cycle.
REQ-009 StallD  in  1  hazard unit: hold decode registers.
REQ-010 PCSrcE  in  1  taken branch/jump redirect from execute.
REQ-011 PCTargetE  in  32  redirect target.
REQ-012 InstrD  out  32  decode-stage instruction.
REQ-013 PCD, PCPlus4D  out  32 each  PC and PC+4 of InstrD.
REQ-014 ValidD  out  1  InstrD is a real fetched instruction.
REQ-015 OpD[6:0], Funct3D[2:0], Funct7_5D  out  field slices InstrD[6:0], [14:12], [30], feeding decode control.

Function
REQ-016 FSM states IDLE, FETCH, DRAIN; IDLE lasts exactly one cycle after reset release, then FETCH.
REQ-017 IMemReq = 1 in DRAIN, and in FETCH when skid buffer empty; 0 in IDLE.
REQ-018 IMemAddr = PCF in FETCH; held at the outstanding address in DRAIN; stable while IMemReq=1 and IMemValid=0.
REQ-019 Response accepted when state=FETCH, IMemReq=1, IMemValid=1, PCSrcE=0; PCF <= PCF+4 (modulo 2^32) same edge.
REQ-020 Accepted response with StallD=0 loads InstrD=IMemRData, PCD=address, PCPlus4D=address+4, ValidD=1 next edge.
REQ-021 Accepted response with StallD=1 goes to one-entry skid buffer (instr, PC); decode registers hold.
REQ-022 StallD=0 with buffer full: decode registers load from buffer, buffer clears; IMemReq reasserts next cycle.
REQ-023 StallD=0, buffer empty, no accepted response: ValidD <= 0, InstrD <= NOP_INSTR (bubble).
REQ-024 PCSrcE=1 (any state): PCF <= {PCTargetE[31:2],2'b00}; buffer cleared; InstrD <= NOP_INSTR, ValidD <= 0, overriding StallD.
REQ-025 PCSrcE=1 in FETCH with request outstanding and IMemValid=0: next state DRAIN; with IMemValid=1 same cycle: response discarded, stay FETCH.
REQ-026 DRAIN: wait for IMemValid, discard data, then FETCH at redirected PCF; further PCSrcE in DRAIN updates PCF, stays DRAIN.
REQ-027 Priority: reset > PCSrcE > StallD > normal fetch.
REQ-028 Throughput one instruction per cycle when IMemValid answers same cycle and StallD=0.

Reset
REQ-029 On reset: PCF=RESET_PC, state=IDLE, IMemReq=0, buffer empty, InstrD=NOP_INSTR, PCD=0, PCPlus4D=0, ValidD=0.
REQ-030 Reset mid-request abandons the outstanding response; memory handshake restarts from RESET_PC.

Structure
REQ-031 Shared package riscv_pkg holds NOP_INSTR, default RESET_PC, fetch_state_t enum (IDLE, FETCH, DRAIN).
REQ-032 Skid buffer is one sub-module fetch_skid_buf (valid, instr, PC; load/clear).
REQ-033 PC+4 adder and redirect mux stay inline in fetch_stage.

Verification
REQ-034 Reset, IMemValid tied 1 -> IMemAddr 0x0,0x4,0x8 on cycles 2,3,4; PCD 0x0,0x4 one cycle later, ValidD=1.
REQ-035 StallD=1 two cycles as 0x8 response returns -> InstrD holds 0x4 instr, 0x8 buffered, IMemReq=0; StallD=0 -> PCD=0x8, fetch resumes at 0xC.
REQ-036 PCSrcE=1, PCTargetE=0x100 with IMemValid same cycle -> response dropped, ValidD=0, InstrD=0x00000013, next IMemAddr=0x100.
REQ-037 PCSrcE=1, target 0x200, IMemValid delayed 3 cycles -> DRAIN, IMemAddr held at old address, data discarded, then IMemAddr=0x200.
REQ-038 PCSrcE=1 with StallD=1, buffer full -> buffer cleared, ValidD=0; PCTargetE=0x203 -> IMemAddr=0x200.
REQ-039 PCF=0xFFFF_FFFC accepted -> next IMemAddr=0x0000_0000, PCPlus4D=0x0.
